// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the 7-segment display driver: conversion FSM states,
// conversion length and the segment patterns (active-high, bit0 = segment a).
// No ports.
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // One shift-add-3 step per magnitude bit.
    localparam int CONV_CYCLES = 8;

    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index n holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Non-decimal codes cannot come out of the converter; they map to blank.
    function automatic logic [6:0] seg_of(input logic [3:0] bcd);
        logic [6:0] s;
        s = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (bcd == 4'(i)) s = SEG_DIGIT[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/display_driver_bin2bcd8.sv
// -----------------------------------------------------------------------------
// bin2bcd8
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, one bit per
// clock).
//   clk, clr   : clock, asynchronous active-low reset
//   i_start    : load i_mag and begin a conversion (restarts one in flight)
//   i_mag      : 8-bit unsigned magnitude
//   o_last     : high during the cycle whose edge performs the final step
//   o_done     : result valid; held until the next i_start
//   o_bcd      : {hundreds, tens, ones}
// -----------------------------------------------------------------------------
module bin2bcd8
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        i_start,
    input  logic [7:0]  i_mag,
    output logic        o_last,
    output logic        o_done,
    output logic [11:0] o_bcd
);

    logic [7:0]  r_shift;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_run;
    logic        r_done;
    logic [11:0] w_adj;

    // Correct every nibble that would reach 10 or more after the shift.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        w_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign o_last = r_run && (r_cnt == 4'(CONV_CYCLES - 1));
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_start) begin
            r_shift <= i_mag;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b1;
            r_done  <= 1'b0;
        end else if (r_run) begin
            // Hundreds never exceeds 2 for an 8-bit input, so bit 11 is unused.
            r_bcd   <= {w_adj[10:0], r_shift[7]};
            r_shift <= {r_shift[6:0], 1'b0};
            r_cnt   <= r_cnt + 4'd1;
            if (o_last) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_driver.sv
// -----------------------------------------------------------------------------
// display_driver
// Captures values written to the CPU output register and shows them in decimal
// on a 4-digit multiplexed common-cathode 7-segment display.
//   SCAN_DIV     : clocks each digit stays enabled (1..65535)
//   clk, clr     : clock, asynchronous active-low reset
//   out_load     : output-register load strobe
//   display_data : output-register value
//   signed_mode  : treat the value as two's complement
//   seg          : segments a..g, active-high, bit0 = a
//   digit        : one-hot digit enable, digit[0] = ones, digit[3] = sign
//   busy         : conversion in progress
// -----------------------------------------------------------------------------
module display_driver
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       out_load,
    input  logic [7:0] display_data,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic [3:0] digit,
    output logic       busy
);

    state_t      r_state, w_state_next;
    logic        r_pend_v, r_pend_sgn;
    logic [7:0]  r_pend_val;
    logic        r_conv_neg;
    logic [11:0] r_disp_bcd;
    logic        r_disp_neg;
    logic [15:0] r_scan_cnt;
    logic [1:0]  r_idx;
    logic [6:0]  r_seg;
    logic [3:0]  r_digit;

    logic        w_start, w_from_pend, w_pend_wr, w_commit;
    logic        w_last, w_done;
    logic [11:0] w_bcd;
    logic [7:0]  w_src_val, w_mag;
    logic        w_neg;
    logic        w_wrap;
    logic [1:0]  w_idx_next;
    logic [6:0]  w_seg_next;

    // ---------------- capture ----------------
    assign w_src_val = w_from_pend ? r_pend_val : display_data;
    assign w_neg     = (w_from_pend ? r_pend_sgn : signed_mode) & w_src_val[7];
    // 8-bit negation: 0x80 stays 0x80, which reads as 128 unsigned.
    assign w_mag     = w_neg ? (~w_src_val + 8'd1) : w_src_val;

    bin2bcd8 u_conv (
        .clk     (clk),
        .clr     (clr),
        .i_start (w_start),
        .i_mag   (w_mag),
        .o_last  (w_last),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // ---------------- control FSM ----------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_from_pend  = 1'b0;
        w_pend_wr    = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pend_v) begin
                    // A write in the same cycle refills the slot we are draining.
                    w_start      = 1'b1;
                    w_from_pend  = 1'b1;
                    w_pend_wr    = out_load;
                    w_state_next = ST_CONV;
                end else if (out_load) begin
                    w_start      = 1'b1;
                    w_state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                w_pend_wr = out_load;
                if (w_last) w_state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_pend_wr    = out_load;
                w_commit     = w_done;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= ST_IDLE;
            r_pend_v   <= 1'b0;
            r_pend_val <= '0;
            r_pend_sgn <= 1'b0;
            r_conv_neg <= 1'b0;
            r_disp_bcd <= '0;
            r_disp_neg <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pend_wr) begin
                r_pend_v   <= 1'b1;
                r_pend_val <= display_data;
                r_pend_sgn <= signed_mode;
            end else if (w_from_pend) begin
                r_pend_v   <= 1'b0;
            end
            if (w_start) r_conv_neg <= w_neg;
            // Display registers change only here, so a partial result never shows.
            if (w_commit) begin
                r_disp_bcd <= w_bcd;
                r_disp_neg <= r_conv_neg;
            end
        end
    end

    // ---------------- scan ----------------
    assign w_wrap     = (r_scan_cnt == 16'(SCAN_DIV - 1));
    assign w_idx_next = r_idx + 2'd1;

    always_comb begin
        w_seg_next = SEG_BLANK;
        unique case (w_idx_next)
            2'd0: w_seg_next = seg_of(r_disp_bcd[3:0]);
            2'd1: w_seg_next = (r_disp_bcd[11:4] == 8'd0) ? SEG_BLANK
                                                          : seg_of(r_disp_bcd[7:4]);
            2'd2: w_seg_next = (r_disp_bcd[11:8] == 4'd0) ? SEG_BLANK
                                                          : seg_of(r_disp_bcd[11:8]);
            2'd3: w_seg_next = r_disp_neg ? SEG_MINUS : SEG_BLANK;
            default: w_seg_next = SEG_BLANK;
        endcase
    end

    // Outputs are reloaded only when the digit advances, so a commit never
    // tears the digit currently lit; it appears when each digit comes round.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_seg      <= SEG_DIGIT[0];
            r_digit    <= 4'b0001;
        end else if (w_wrap) begin
            r_scan_cnt <= '0;
            r_idx      <= w_idx_next;
            r_seg      <= w_seg_next;
            r_digit    <= 4'b0001 << w_idx_next;
        end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
        end
    end

    assign seg   = r_seg;
    assign digit = r_digit;

endmodule

// File: doc/display_driver.md
# display_driver

Downstream consumer of the CPU output register: captures each value written to `display_data` and shows it as a decimal number on a four-digit, time-multiplexed, common-cathode 7-segment display. Binary-to-BCD conversion is sequential, using shift-add-3 with one bit per cycle. A one-deep pending slot absorbs back-to-back writes. Sits beside `cpu` in the top level, fed by its output-register bus and load strobe.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit stays enabled. Legal range is 1 to 65535.
- `clk` in 1: system clock, rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `out_load` in 1: output-register load strobe (OI), sampled on the rising edge.
- `display_data` in 8: output-register value.
- `signed_mode` in 1: interpret captured value as two's complement. Sampled together with the value.
- `seg` out 7: segments a..g, active-high, bit0 = a.
- `digit` out 4: one-hot digit enable, active-high. `digit[0]` = ones, `digit[3]` = leftmost/sign.
- `busy` out 1: conversion in progress.

## Operation
- **States** (FSM with three states):
  - IDLE → CONV on start; CONV stays for 8 cycles, then → COMMIT; COMMIT → IDLE after one cycle.
- **Start condition (IDLE only)**:
  - If `pend_v` is set, start from the pending value/mode and clear `pend_v`.
  - Otherwise, if `out_load` is high, start from `display_data`/`signed_mode`.
- **Capture**:
  - If signed and bit7 is set: `neg`=1 and magnitude = two's-complement negation, computed 8-bit unsigned (0x80 → 128).
  - Otherwise: `neg`=0 and magnitude = value.
- **CONV**: per cycle, add 3 to each BCD nibble ≥5, then shift left one bit with the next magnitude MSB entering. Produces a 12-bit BCD result (hundreds, tens, ones).
- **COMMIT**: copy BCD + `neg` atomically into the display registers. The displayed value never shows a partial conversion.
- **Pending slot**:
  - `out_load` seen while `busy`=1, or while in IDLE and starting from `pend_v`, writes the pending slot. The most recent write wins, so earlier pending values are dropped.
  - Exactly one conversion follows.
- **Blanking**:
  - Hundreds is blank if 0.
  - Tens is blank if hundreds = 0 and tens = 0.
  - Ones always shows.
  - `digit[3]` shows '-' (seg 0x40) if `neg`, else blank (0x00).
- **Segment codes** 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- **Scan**:
  - A free-running counter of 0..SCAN_DIV-1 advances the digit index 0→1→2→3→0 on wrap.
  - `seg`/`digit` are registered from the index and display registers.
  - Scanning is independent of conversion.

## Timing
- **Reset values** (all immediate on `clr` low):
  - FSM = IDLE, `busy`=0, `pend_v`=0.
  - Display registers = value 0, `neg`=0.
  - Scan counter = 0, index = 0.
  - `digit`=4'b0001, `seg`=7'h3F.
- **Conversion latency**:
  - `out_load` sampled at edge k (IDLE, no pending).
  - `busy`=1 after edge k.
  - CONV occupies edges k+1..k+8.
  - COMMIT at edge k+9: display registers update and `busy` returns to 0.
- **Display latency**: new value reaches `seg` on the first scan edge after k+9 that selects the digit. There is no tearing within a digit period.
- **Back-to-back writes**:
  - `out_load` at edge k+9 (COMMIT) goes to pending.
  - The next conversion starts at edge k+10 from pending.
- **Continuous `out_load`**: sustained `out_load` in IDLE produces back-to-back conversions, 10 cycles apart.
- **Reset mid-conversion**: aborts the conversion and discards the partial BCD and pending value. The display returns to "0".

## Structure
- **Package `display_pkg`**:
  - FSM state enum (IDLE, CONV, COMMIT).
  - Segment constants: digits 0–9, `SEG_MINUS`=7'h40, `SEG_BLANK`=7'h00.
  - `CONV_CYCLES`=8.
- **Sub-module `bin2bcd8`**:
  - Contains the sequential shift-add-3 converter with a start/done handshake.
  - Takes an 8-bit magnitude and outputs 12-bit BCD.
  - `display_driver` owns the capture, pending slot, commit, blanking and scan logic.

## Test plan
- **Reset with no load** (SCAN_DIV=4):
  - `digit` cycles 0001→0010→0100→1000, 4 cycles each.
  - `seg`=3F on `digit[0]`, 00 on the others.
- **Unsigned 0xFF**: `busy` high for 9 cycles, then digits read 2,5,5 (5B,6D,6D) and `digit[3]`=00.
- **Signed 0xFF**: ones=06, tens/hundreds=00, `digit[3]`=40 ("-1").
- **Signed 0x80** → "-128": 40, 06, 5B, 7F.
- **Write burst**:
  - Stimulus: 0x07 at edge k, 0x2A at k+3, 0x63 at k+4.
  - Required response: "7" commits at k+9, then "99" at k+19.
  - 0x2A is never displayed.
- **Reset mid-conversion**:
  - Stimulus: `clr` low at k+5 during conversion of 0xC8.
  - Required response: outputs go to reset values immediately, `busy`=0, and no later commit of 200 occurs.
